pipeline_hazard_ctrl: RTL and testbench

// - Hazard scheduler for the 5-stage core (IF/ID/EX/MEM/WB). It sequences the operand-forwarding path.
// - Tracks destination regs of in-flight EX/MEM ops and picks a forwarding source per operand.
// - Inserts load-use stalls, freezes the pipe on data-memory wait and multi-cycle EX ops, flushes on taken branch.
// - Sits beside the ID/EX pipe registers; drives pipe-register enables/clears and forwarding-mux selects.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 39 +++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// stall FSM states and the shadow copies of the EX and MEM pipe stages.
package pipeline_hazard_ctrl_pkg;

  // Width of a register address held in the shadow stages.
  localparam int SHADOW_RD_W = 5;

  // Operand source for the ID/EX forwarding muxes.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Stall FSM: RUN, or frozen waiting on data memory / multi-cycle EX unit.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MUL_WAIT = 2'd2
  } hz_state_e;

  // Shadow of the instruction currently in EX.
  typedef struct packed {
    logic                   v;
    logic [SHADOW_RD_W-1:0] rd;
    logic                   we;
    logic                   load;
    logic                   mul;
  } shadow_t;

  // Shadow of the instruction currently in MEM (multi-cycle flag no longer needed).
  typedef struct packed {
    logic                   v;
    logic [SHADOW_RD_W-1:0] rd;
    logic                   we;
    logic                   load;
  } mem_shadow_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Per-operand forwarding source picker. Compares one ID source register
// against the EX and MEM shadow destinations; EX wins over MEM, x0 is
// never forwarded, and a match against an EX load is reported as load-use.
module pipeline_hazard_ctrl_fwd_select
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = SHADOW_RD_W
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  re_i,
  input  logic                  ex_v_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_we_i,
  input  logic                  ex_load_i,
  input  logic                  mem_v_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_we_i,
  output fwd_sel_e              sel_o,
  output logic                  load_use_o
);

  logic ex_hit;
  logic mem_hit;

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  assign ex_hit  = re_i && (rs_i != '0) && ex_v_i  && ex_we_i  && (rs_i == ex_rd_i);
  assign mem_hit = re_i && (rs_i != '0) && mem_v_i && mem_we_i && (rs_i == mem_rd_i);

  // A load in EX has no data yet; that case becomes a load-use stall instead.
  assign load_use_o = ex_hit && ex_load_i;

  // Pick the youngest producer: EX result first, then MEM, else regfile.
  always_comb begin
    sel_o = FWD_REG;
    if (ex_hit && !ex_load_i) begin
      sel_o = FWD_EX;
    end else if (mem_hit) begin
      sel_o = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the 5-stage core. Keeps a shadow of the EX/MEM
// destination registers, drives the forwarding selects, inserts load-use
// bubbles, freezes the back end on memory / multi-cycle waits and flushes
// on a taken branch. Also counts PC-stall cycles (saturating).
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = SHADOW_RD_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_re_i,
  input  logic                  id_rs2_re_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_we_i,
  input  logic                  id_is_load_i,
  input  logic                  id_is_mul_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mul_done_i,
  input  logic                  mem_ready_i,
  output logic                  stall_pc_o,
  output logic                  stall_ifid_o,
  output logic                  flush_ifid_o,
  output logic                  bubble_idex_o,
  output logic                  freeze_back_o,
  output logic [1:0]            fwd_sel1_o,
  output logic [1:0]            fwd_sel2_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  shadow_t          ex_q, ex_d;
  mem_shadow_t      mem_q, mem_d;
  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REG_ADDR_W-1:0] rs_a  [2];
  logic                  re_a  [2];
  fwd_sel_e              sel_a [2];
  logic                  lu_a  [2];

  logic mem_hold;
  logic mul_hold;
  logic load_use;
  logic frozen;

  assign rs_a[0] = id_rs1_i;
  assign rs_a[1] = id_rs2_i;
  assign re_a[0] = id_rs1_re_i;
  assign re_a[1] = id_rs2_re_i;

  // One forwarding picker per ID source operand.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    pipeline_hazard_ctrl_fwd_select #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
      .rs_i       (rs_a[gi]),
      .re_i       (re_a[gi]),
      .ex_v_i     (ex_q.v),
      .ex_rd_i    (ex_q.rd),
      .ex_we_i    (ex_q.we),
      .ex_load_i  (ex_q.load),
      .mem_v_i    (mem_q.v),
      .mem_rd_i   (mem_q.rd),
      .mem_we_i   (mem_q.we),
      .sel_o      (sel_a[gi]),
      .load_use_o (lu_a[gi])
    );
  end

  // Wait conditions are evaluated combinationally so release costs no cycle.
  assign mem_hold = mem_q.v && mem_q.load && !mem_ready_i;
  assign mul_hold = ex_q.v && ex_q.mul && !mul_done_i;
  assign load_use = id_valid_i && (lu_a[0] || lu_a[1]);

  // Next-state and control outputs; memory wait outranks multi-cycle wait,
  // which outranks branch flush, which outranks load-use stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d = MEM_WAIT;
        end else if (mul_hold) begin
          state_d = MUL_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!mem_hold) begin
          state_d = mul_hold ? MUL_WAIT : RUN;
        end
      end
      MUL_WAIT: begin
        if (mem_hold) begin
          state_d = MEM_WAIT;
        end else if (!mul_hold) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    frozen        = (state_d != RUN);
    stall_pc_o    = 1'b0;
    stall_ifid_o  = 1'b0;
    flush_ifid_o  = 1'b0;
    bubble_idex_o = 1'b0;
    freeze_back_o = 1'b0;
    fwd_sel1_o    = sel_a[0];
    fwd_sel2_o    = sel_a[1];

    if (rst) begin
      state_d    = RUN;
      fwd_sel1_o = FWD_REG;
      fwd_sel2_o = FWD_REG;
    end else if (frozen) begin
      // A branch held in EX during the freeze flushes on the release cycle.
      freeze_back_o = 1'b1;
      stall_pc_o    = 1'b1;
      stall_ifid_o  = 1'b1;
    end else if (ex_branch_taken_i) begin
      // The instruction in ID is wrong-path, so any load-use on it is dropped.
      flush_ifid_o  = 1'b1;
      bubble_idex_o = 1'b1;
    end else if (load_use) begin
      stall_pc_o    = 1'b1;
      stall_ifid_o  = 1'b1;
      bubble_idex_o = 1'b1;
    end
  end

  // Shadow-stage next values and saturating stall counter increment.
  always_comb begin
    ex_d.v     = id_valid_i && !bubble_idex_o;
    ex_d.rd    = id_rd_i;
    ex_d.we    = id_we_i;
    ex_d.load  = id_is_load_i;
    ex_d.mul   = id_is_mul_i;
    mem_d.v    = ex_q.v;
    mem_d.rd   = ex_q.rd;
    mem_d.we   = ex_q.we;
    mem_d.load = ex_q.load;
    cnt_d      = cnt_q;
    if (stall_pc_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, shadow pipe and counter registers; shadow holds while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!freeze_back_o) begin
        ex_q  <= ex_d;
        mem_q <= mem_d;
      end
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a behavioural pipeline model
// predicts every output each cycle, and literal expectations pin key points.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       rs1, rs2, rd;
  logic             re1, re2, we, ld, mul;
  logic             branch, mul_done, mem_ready;
  logic             stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze_back;
  logic [1:0]       sel1, sel2;
  logic [CNT_W-1:0] cnt;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid_i        (id_valid),
    .id_rs1_i          (rs1),
    .id_rs2_i          (rs2),
    .id_rs1_re_i       (re1),
    .id_rs2_re_i       (re2),
    .id_rd_i           (rd),
    .id_we_i           (we),
    .id_is_load_i      (ld),
    .id_is_mul_i       (mul),
    .ex_branch_taken_i (branch),
    .mul_done_i        (mul_done),
    .mem_ready_i       (mem_ready),
    .stall_pc_o        (stall_pc),
    .stall_ifid_o      (stall_ifid),
    .flush_ifid_o      (flush_ifid),
    .bubble_idex_o     (bubble_idex),
    .freeze_back_o     (freeze_back),
    .fwd_sel1_o        (sel1),
    .fwd_sel2_o        (sel2),
    .stall_cnt_o       (cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_step = 0;

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
    bit       mul;
  } instr_t;

  typedef struct packed {
    bit       stall_pc;
    bit       stall_ifid;
    bit       flush;
    bit       bubble;
    bit       freeze;
    bit [1:0] s1;
    bit [1:0] s2;
  } exp_t;

  instr_t m_ex, m_mem;
  int     m_cnt;
  bit     started = 1'b0;
  exp_t   exp_now;

  // Does the instruction in this slot produce the value register rs needs?
  function automatic bit produces(input instr_t s, input bit [4:0] r, input bit re);
    return re && (r != 5'd0) && s.v && s.we && (s.rd == r);
  endfunction

  function automatic bit [1:0] source(input bit [4:0] r, input bit re);
    if (produces(m_ex, r, re) && !m_ex.ld) return 2'b01;
    if (produces(m_mem, r, re)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit   hold;
    bit   lu;
    e = '0;
    if (rst) return e;
    e.s1 = source(rs1, re1);
    e.s2 = source(rs2, re2);
    hold = (m_mem.v && m_mem.ld && !mem_ready) || (m_ex.v && m_ex.mul && !mul_done);
    lu   = id_valid && m_ex.ld && (produces(m_ex, rs1, re1) || produces(m_ex, rs2, re2));
    if (hold) begin
      e.freeze = 1; e.stall_pc = 1; e.stall_ifid = 1;
    end else if (branch) begin
      e.flush = 1; e.bubble = 1;
    end else if (lu) begin
      e.stall_pc = 1; e.stall_ifid = 1; e.bubble = 1;
    end
    return e;
  endfunction

  always_comb exp_now = predict();

  // Model pipeline advance.
  always @(posedge clk) begin
    if (rst) begin
      m_ex    <= '0;
      m_mem   <= '0;
      m_cnt   <= 0;
      started <= 1'b1;
    end else begin
      if (exp_now.stall_pc && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      if (!exp_now.freeze) begin
        m_mem <= m_ex;
        m_ex  <= '{v: id_valid && !exp_now.bubble, rd: rd, we: we, ld: ld, mul: mul};
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      check("stall_pc", {31'd0, stall_pc}, {31'd0, exp_now.stall_pc});
      check("stall_ifid", {31'd0, stall_ifid}, {31'd0, exp_now.stall_ifid});
      check("flush_ifid", {31'd0, flush_ifid}, {31'd0, exp_now.flush});
      check("bubble_idex", {31'd0, bubble_idex}, {31'd0, exp_now.bubble});
      check("freeze_back", {31'd0, freeze_back}, {31'd0, exp_now.freeze});
      check("fwd_sel1", {30'd0, sel1}, {30'd0, exp_now.s1});
      check("fwd_sel2", {30'd0, sel2}, {30'd0, exp_now.s2});
      check("stall_cnt", 32'(cnt), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_id();
    id_valid = 0; rs1 = 0; re1 = 0; rs2 = 0; re2 = 0; rd = 0; we = 0; ld = 0; mul = 0;
  endtask

  task automatic set_id(input bit [4:0] r1, input bit e1, input bit [4:0] r2, input bit e2,
                        input bit [4:0] d, input bit w, input bit l, input bit m);
    id_valid = 1; rs1 = r1; re1 = e1; rs2 = r2; re2 = e2; rd = d; we = w; ld = l; mul = m;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    branch = 0; mul_done = 0; mem_ready = 1;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    n_step++;
    $display("step %0d %-12s pc=%0b ifid=%0b fl=%0b bub=%0b frz=%0b sel=%0d/%0d cnt=%0d",
             n_step, tag, stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze_back,
             sel1, sel2, cnt);
  endtask

  initial begin
    rst = 1; branch = 0; mul_done = 0; mem_ready = 1;
    idle_id();
    repeat (2) @(posedge clk);
    #1;
    step("reset");
    check("lit_rst_stall", {31'd0, stall_pc}, 32'd0);
    check("lit_rst_cnt", 32'(cnt), 32'd0);

    nxt(); rst = 0; set_id(0, 0, 0, 0, 5, 1, 0, 0);       // add x5
    step("add_x5");
    check("lit_empty_sel1", {30'd0, sel1}, 32'd0);

    nxt(); set_id(5, 1, 0, 0, 0, 1, 0, 0);                // reads x5, writes x0
    step("use_x5");
    check("lit_fwd_ex", {30'd0, sel1}, 32'd1);
    check("lit_fwd_ex_nostall", {31'd0, stall_pc}, 32'd0);

    nxt(); set_id(0, 1, 5, 1, 5, 1, 0, 0);                // x0 in EX, x5 only in MEM
    step("x0_and_mem");
    check("lit_x0", {30'd0, sel1}, 32'd0);
    check("lit_fwd_mem", {30'd0, sel2}, 32'd2);

    nxt(); set_id(5, 1, 0, 0, 5, 1, 0, 0);
    step("ex_x5");
    nxt(); set_id(5, 1, 0, 0, 9, 1, 0, 0);                // x5 in EX and MEM
    step("prio");
    check("lit_prio_ex", {30'd0, sel1}, 32'd1);

    nxt(); set_id(0, 0, 0, 0, 7, 1, 1, 0);                // lw x7
    step("lw_x7");
    nxt(); set_id(0, 0, 7, 1, 8, 1, 0, 0);                // uses x7
    step("load_use");
    check("lit_lu_stall", {31'd0, stall_pc}, 32'd1);
    check("lit_lu_bubble", {31'd0, bubble_idex}, 32'd1);
    nxt();
    step("lu_after");
    check("lit_lu_fwd_mem", {30'd0, sel2}, 32'd2);
    check("lit_lu_nostall", {31'd0, stall_pc}, 32'd0);
    check("lit_lu_cnt", 32'(cnt), 32'd1);

    nxt(); set_id(0, 0, 0, 0, 10, 1, 1, 0);               // lw x10
    step("lw_x10");
    nxt(); set_id(0, 0, 0, 0, 11, 1, 0, 0);
    step("nop");
    repeat (3) begin
      nxt(); mem_ready = 0;
      step("mem_wait");
      check("lit_memwait_frz", {31'd0, freeze_back}, 32'd1);
    end
    nxt();
    step("mem_ready");
    check("lit_memrel_frz", {31'd0, freeze_back}, 32'd0);
    check("lit_memrel_cnt", 32'(cnt), 32'd4);

    nxt(); set_id(0, 0, 0, 0, 12, 1, 0, 1);               // mul x12
    step("mul_x12");
    nxt(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step("mul_wait");
    check("lit_mulwait_frz", {31'd0, freeze_back}, 32'd1);
    repeat (3) begin
      nxt();
      step("mul_wait");
      check("lit_mulwait_frz", {31'd0, freeze_back}, 32'd1);
    end
    nxt(); mul_done = 1;
    step("mul_done");
    check("lit_mulrel_frz", {31'd0, freeze_back}, 32'd0);
    check("lit_mulrel_cnt", 32'(cnt), 32'd8);

    nxt(); set_id(0, 0, 0, 0, 13, 1, 1, 0);               // lw x13
    step("lw_x13");
    nxt(); set_id(13, 1, 0, 0, 14, 1, 0, 0); branch = 1;   // load-use + branch
    step("br_vs_lu");
    check("lit_br_flush", {31'd0, flush_ifid}, 32'd1);
    check("lit_br_nostall", {31'd0, stall_pc}, 32'd0);

    nxt(); set_id(0, 0, 0, 0, 14, 1, 0, 1);               // mul x14
    step("mul_x14");
    nxt(); set_id(0, 0, 0, 0, 0, 0, 0, 0); branch = 1;
    step("br_frozen");
    check("lit_brfrz_noflush", {31'd0, flush_ifid}, 32'd0);
    check("lit_brfrz_stall", {31'd0, stall_pc}, 32'd1);
    nxt(); branch = 1; mul_done = 1;
    step("br_release");
    check("lit_brrel_flush", {31'd0, flush_ifid}, 32'd1);
    check("lit_brrel_cnt", 32'(cnt), 32'd9);

    nxt(); set_id(0, 0, 0, 0, 15, 1, 1, 0);               // lw x15
    step("lw_x15");
    nxt(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step("nop");
    nxt(); mem_ready = 0;
    step("mem_wait");
    check("lit_pre_rst_frz", {31'd0, freeze_back}, 32'd1);
    nxt(); mem_ready = 0; rst = 1;
    step("rst_in_wait");
    check("lit_rstw_frz", {31'd0, freeze_back}, 32'd0);
    nxt(); mem_ready = 0; rst = 0; idle_id();
    step("after_rst");
    check("lit_after_rst_frz", {31'd0, freeze_back}, 32'd0);
    check("lit_after_rst_cnt", 32'(cnt), 32'd0);

    nxt(); set_id(0, 0, 0, 0, 16, 1, 1, 0);               // lw x16
    step("lw_x16");
    nxt(); set_id(16, 1, 0, 0, 17, 1, 0, 0); id_valid = 0; // invalid ID: no stall
    step("id_invalid");
    check("lit_inv_nostall", {31'd0, stall_pc}, 32'd0);
    check("lit_inv_nobubble", {31'd0, bubble_idex}, 32'd0);
    repeat (70) begin
      nxt(); idle_id(); mem_ready = 0;
      step("long_wait");
    end
    nxt();
    step("sat_release");
    check("lit_sat_cnt", 32'(cnt), 32'(CMAX));
    nxt();
    step("tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
